asyalu_seq_ctrl: RTL and testbench
==================================

// Module: asyalu_seq_ctrl
// PURPOSE
//  Clocked sequencer for the asynchronous dual-rail ALU core. Buffers op commands, drives the
//  core's 4-phase (return-to-zero) start/ack handshake, and synchronises ack into clk.
//  Captures dout/flag and returns them on a valid/ready result port.
//  Sits between the chip's synchronous logic and the ALU core; sole driver of its clr_n/start/op.
// PARAMETERS
//  FIFO_DEPTH      4   command FIFO entries, power of 2, >=2
//  SYNC_STAGES     2   flops in the ack synchroniser, >=2
//  SETTLE_CYCLES   1   cycles alu_op is held stable before alu_start rises (bundled-data setup)
//  CLR_CYCLES      2   cycles alu_clr_n is held low in CLEAR
//  TIMEOUT_CYCLES  64  max cycles waiting on an ack edge (ASYSEQ_TIMEOUT_EN only)
// PORTS
//  clk        in   1  clock
//  rst_n      in   1  asynchronous active-low reset
//  cmd_valid  in   1  command valid
//  cmd_ready  out  1  FIFO not full
//  cmd_op     in   4  ALU opcode
//  res_valid  out  1  result register holds a result
//  res_ready  in   1  consumer accepts result
//  res_data   out  4  captured alu_dout
//  res_flag   out  1  captured alu_flag
//  res_err    out  1  result produced by timeout; data invalid
//  busy       out  1  FSM not in IDLE, or FIFO non-empty
//  alu_clr_n  out  1  core clear, active low
//  alu_start  out  1  core request
//  alu_op     out  4  core opcode, registered
//  alu_ack    in   1  core acknowledge, asynchronous to clk
//  alu_dout   in   4  core result, stable while alu_ack=1
//  alu_flag   in   1  core flag, stable while alu_ack=1
// BEHAVIOUR
//  Reset values:
//   - alu_clr_n=0, alu_start=0, alu_op=0; res_valid=0, res_data=0, res_flag=0, res_err=0.
//   - cmd_ready=0, busy=1; FIFO empty; synchroniser cleared; FSM=CLEAR.
//  ack_s = alu_ack after SYNC_STAGES flops. No other logic samples alu_ack.
//  FSM:
//   - CLEAR: alu_clr_n=0, alu_start=0 for CLR_CYCLES cycles, then IDLE (alu_clr_n=1).
//     cmd_ready=0 in CLEAR.
//   - IDLE: when FIFO non-empty, pop, load alu_op, go SETUP.
//   - SETUP: hold alu_op for SETTLE_CYCLES cycles, then REQ with alu_start=1.
//     Pop to alu_start rise = SETTLE_CYCLES+1 cycles.
//   - REQ: wait for ack_s=1. If res_valid=0 or res_ready=1 that cycle, load res_data/res_flag,
//     res_err=0, res_valid=1, then REL. Otherwise stay in REQ with alu_start held at 1,
//     so core data stays stable (back-pressure).
//   - REL: alu_start=0; wait ack_s=0, then IDLE. An op may be popped in the same cycle.
//  alu_op is constant from SETUP entry until REL exit. alu_start never rises while ack_s=1.
//  FIFO:
//   - Push when cmd_valid & cmd_ready. Full: cmd_ready=0, command not accepted.
//   - Push and pop in the same cycle are both legal at any fill level.
//   - Pointers wrap modulo FIFO_DEPTH.
//  Result register:
//   - res_valid clears on res_valid & res_ready unless reloaded that same cycle.
//   - Simultaneous consume and capture: new result wins, res_valid stays 1.
//  Reset mid-operation: immediate return to reset values, including alu_start=0 and
//   alu_clr_n=0. Queued commands and the pending result are discarded.
// CONFIGURATION
//  ASYSEQ_TIMEOUT_EN defined:
//   - A cycle counter runs in REQ (only while waiting for ack_s=1) and in REL.
//   - On reaching TIMEOUT_CYCLES: alu_start=0, go CLEAR; result is posted when the result
//     register is free: res_valid=1, res_err=1, res_data=0, res_flag=0.
//   - The FIFO is kept; sequencing resumes after CLEAR.
//  ASYSEQ_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely; res_err tied 0.
// STRUCTURE
//  Package asyseq_pkg:
//   - ALU_OP_W=4, ALU_D_W=4.
//   - typedef enum asyseq_state_t {CLEAR, IDLE, SETUP, REQ, REL}.
//   - Counter width function clog2-based.
//  Sub-module asyseq_cmd_fifo: synchronous FIFO, WIDTH=ALU_OP_W, DEPTH=FIFO_DEPTH,
//   with full/empty outputs.
//  Synchroniser, FSM, result register and timeout counter are inline.
// TESTING  (bench models the core: ack rises N cycles after start, falls M cycles after release)
//  1. Reset release -> alu_clr_n low exactly 2 cycles, then cmd_ready=1, busy=0.
//  2. Push op 4'h3, core returns dout=4'hA, flag=1 -> alu_start rises 2 cycles after pop;
//     res_valid=1, res_data=4'hA, res_flag=1, res_err=0; alu_start released only after capture.
//  3. Push 5 ops back-to-back with depth 4 and core stalled -> 5th push refused (cmd_ready=0);
//     all accepted ops complete in order, matching res_data.
//  4. Hold res_ready=0 over two ops -> second op stays in REQ with alu_start=1 and alu_op stable;
//     captured one cycle after res_ready=1.
//  5. Assert rst_n low while in REQ -> alu_start=0 and alu_clr_n=0 in the same cycle;
//     FIFO empty and res_valid=0 after release.
//  6. ASYSEQ_TIMEOUT_EN defined, ack never rises -> after 64 cycles res_err=1, res_data=0,
//     CLEAR pulse seen, next queued op runs normally.

Source files
------------

// File: rtl/asyseq_pkg.sv
// Shared types and constants for the asynchronous-ALU sequencer.
package asyseq_pkg;

    localparam int ALU_OP_W = 4;
    localparam int ALU_D_W  = 4;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        SETUP,
        REQ,
        REL
    } asyseq_state_t;

    // Width of a counter that runs from 0 to max_count-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/asyalu_seq_ctrl_if.sv
// Bundle of command, result and ALU-core signals around the sequencer.
// master: the sequencer itself; slave: the surrounding logic plus the ALU core.
interface asyalu_seq_ctrl_if;
    import asyseq_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [ALU_OP_W-1:0] cmd_op;
    logic                res_valid;
    logic                res_ready;
    logic [ALU_D_W-1:0]  res_data;
    logic                res_flag;
    logic                res_err;
    logic                busy;
    logic                alu_clr_n;
    logic                alu_start;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_ack;
    logic [ALU_D_W-1:0]  alu_dout;
    logic                alu_flag;

    modport master (
        input  cmd_valid, cmd_op, res_ready, alu_ack, alu_dout, alu_flag,
        output cmd_ready, res_valid, res_data, res_flag, res_err, busy,
               alu_clr_n, alu_start, alu_op
    );

    modport slave (
        output cmd_valid, cmd_op, res_ready, alu_ack, alu_dout, alu_flag,
        input  cmd_ready, res_valid, res_data, res_flag, res_err, busy,
               alu_clr_n, alu_start, alu_op
    );

endinterface

// File: rtl/asyseq_cmd_fifo.sv
// Small synchronous command FIFO with first-word fall-through read.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module asyseq_cmd_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    // Pointer update; wrap is implicit in the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/asyalu_seq_ctrl.sv
// Clocked sequencer for the asynchronous dual-rail ALU core: queues opcodes,
// runs the 4-phase start/ack handshake, synchronises ack and returns results.
// Optional build macro ASYSEQ_TIMEOUT_EN adds an ack watchdog that forces a
// core clear and posts an error result.
module asyalu_seq_ctrl
    import asyseq_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 1,
    parameter int CLR_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    asyalu_seq_ctrl_if.master bus
);
    localparam int CLR_W = cnt_w(CLR_CYCLES);
    localparam int SET_W = cnt_w(SETTLE_CYCLES);

    asyseq_state_t          state_q, state_d;
    logic [CLR_W-1:0]       clr_cnt_q, clr_cnt_d;
    logic [SET_W-1:0]       settle_cnt_q, settle_cnt_d;
    logic [ALU_OP_W-1:0]    alu_op_q, alu_op_d;
    logic                   alu_start_q;
    logic                   alu_clr_n_q;
    logic                   res_valid_q, res_valid_d;
    logic [ALU_D_W-1:0]     res_data_q, res_data_d;
    logic                   res_flag_q, res_flag_d;
    logic [SYNC_STAGES-1:0] sync_q;

    logic                   ack_s;
    logic                   res_free;
    logic                   capture;
    logic                   err_pend;
    logic                   err_load;
    logic                   timeout;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic [ALU_OP_W-1:0]    fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;

    asyseq_cmd_fifo #(
        .WIDTH (ALU_OP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (bus.cmd_op),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.cmd_ready = !fifo_full && (state_q != CLEAR);
    assign fifo_push     = bus.cmd_valid && bus.cmd_ready;
    assign res_free      = !res_valid_q || bus.res_ready;

    // Ack synchroniser: the only place the asynchronous ack enters the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.alu_ack};
        end
    end
    assign ack_s = sync_q[SYNC_STAGES-1];

    // Next-state logic; start only rises once ack_s has returned low.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        settle_cnt_d = settle_cnt_q;
        alu_op_d     = alu_op_q;
        fifo_pop     = 1'b0;
        capture      = 1'b0;
        case (state_q)
            CLEAR: begin
                if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
            end
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    alu_op_d     = fifo_dout;
                    settle_cnt_d = '0;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    if (!ack_s) state_d = REQ;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end
            REQ: begin
                // Holding start high while the result port is blocked keeps core data stable.
                if (ack_s) begin
                    if (res_free && !err_pend) begin
                        capture = 1'b1;
                        state_d = REL;
                    end
                end else if (timeout) begin
                    state_d = CLEAR;
                end
            end
            REL: begin
                if (!ack_s) begin
                    if (!fifo_empty) begin
                        fifo_pop     = 1'b1;
                        alu_op_d     = fifo_dout;
                        settle_cnt_d = '0;
                        state_d      = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timeout) begin
                    state_d = CLEAR;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // State and core-facing registers; start/clr_n come straight from flops so the core never sees glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CLEAR;
            clr_cnt_q    <= '0;
            settle_cnt_q <= '0;
            alu_op_q     <= '0;
            alu_start_q  <= 1'b0;
            alu_clr_n_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            alu_op_q     <= alu_op_d;
            alu_start_q  <= (state_d == REQ);
            alu_clr_n_q  <= (state_d != CLEAR);
        end
    end

    // Result register next value: a fresh load beats a simultaneous consume.
    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_flag_d  = res_flag_q;
        if (capture) begin
            res_valid_d = 1'b1;
            res_data_d  = bus.alu_dout;
            res_flag_d  = bus.alu_flag;
        end else if (err_load) begin
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_flag_d  = 1'b0;
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // Result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flag_q  <= 1'b0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_flag_q  <= res_flag_d;
        end
    end

`ifdef ASYSEQ_TIMEOUT_EN
    localparam int TO_W = cnt_w(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_pend_q, err_pend_d;
    logic            res_err_q;
    logic            waiting;

    // Only genuine waits on an ack edge count; a back-pressured REQ with ack high does not.
    assign waiting    = ((state_q == REQ) && !ack_s) || ((state_q == REL) && ack_s);
    assign timeout    = waiting && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign to_cnt_d   = (waiting && (state_d == state_q)) ? to_cnt_q + TO_W'(1) : '0;
    assign err_pend   = err_pend_q;
    assign err_load   = err_pend_q && res_free;
    assign err_pend_d = (err_pend_q && !err_load) || timeout;

    // Watchdog counter and the pending error result awaiting a free result slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q   <= '0;
            err_pend_q <= 1'b0;
        end else begin
            to_cnt_q   <= to_cnt_d;
            err_pend_q <= err_pend_d;
        end
    end

    // Error flag tracks whichever source loaded the result register last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_err_q <= 1'b0;
        end else if (capture) begin
            res_err_q <= 1'b0;
        end else if (err_load) begin
            res_err_q <= 1'b1;
        end
    end

    assign bus.res_err = res_err_q;
`else
    assign timeout     = 1'b0;
    assign err_pend    = 1'b0;
    assign err_load    = 1'b0;
    assign bus.res_err = 1'b0;
`endif

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_flag  = res_flag_q;
    assign bus.busy      = (state_q != IDLE) || !fifo_empty;
    assign bus.alu_clr_n = alu_clr_n_q;
    assign bus.alu_start = alu_start_q;
    assign bus.alu_op    = alu_op_q;

endmodule

// File: tb/tb_asyalu_seq_ctrl.sv
// Directed bench for asyalu_seq_ctrl with a behavioural ALU core model
// (dout = op ^ 4'h9, flag = op[0]; ack after core_n cycles, release after core_m).
`timescale 1ns/1ps
module tb_asyalu_seq_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    asyalu_seq_ctrl_if bus ();

    asyalu_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int core_n    = 3;
    int core_m    = 2;
    bit core_hold = 1'b0;
    int core_cnt  = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [3:0] op);
        int w = 0;
        bus.cmd_op    = op;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && w < 50) begin
            tick();
            w++;
        end
        check_eq("push_ready", 16'(bus.cmd_ready), 1);
        tick();
        bus.cmd_valid = 1'b0;
        $display("push op=0x%0h", op);
    endtask

    task automatic get_result(input string tag, input logic [3:0] exp_d, input logic exp_f);
        int w = 0;
        bus.res_ready = 1'b1;
        while (!bus.res_valid && w < 200) begin
            tick();
            w++;
        end
        check_eq({tag, "_valid"}, 16'(bus.res_valid), 1);
        check_eq({tag, "_data"},  16'(bus.res_data), 16'(exp_d));
        check_eq({tag, "_flag"},  16'(bus.res_flag), 16'(exp_f));
        check_eq({tag, "_err"},   16'(bus.res_err), 0);
        $display("result %s: data=0x%0h flag=%0b err=%0b wait=%0d", tag,
                 bus.res_data, bus.res_flag, bus.res_err, w);
        tick();
        bus.res_ready = 1'b0;
    endtask

    // Behavioural core: 4-phase handshake, cleared by alu_clr_n.
    initial begin
        bus.alu_ack  = 1'b0;
        bus.alu_dout = 4'h0;
        bus.alu_flag = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !bus.alu_clr_n) begin
                bus.alu_ack = 1'b0;
                core_cnt    = 0;
            end else if (bus.alu_start && !bus.alu_ack && !core_hold) begin
                core_cnt++;
                if (core_cnt >= core_n) begin
                    bus.alu_ack  = 1'b1;
                    bus.alu_dout = bus.alu_op ^ 4'h9;
                    bus.alu_flag = bus.alu_op[0];
                    core_cnt     = 0;
                end
            end else if (!bus.alu_start && bus.alu_ack) begin
                core_cnt++;
                if (core_cnt >= core_m) begin
                    bus.alu_ack = 1'b0;
                    core_cnt    = 0;
                end
            end else begin
                core_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops   [5];
        logic [3:0] exp_d [5];
        logic       exp_f [5];
        int n;
        int w;
        bit early;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'h0;
        bus.res_ready = 1'b0;

        // Reset values
        repeat (3) tick();
        check_eq("rst_clr_n",     16'(bus.alu_clr_n), 0);
        check_eq("rst_start",     16'(bus.alu_start), 0);
        check_eq("rst_alu_op",    16'(bus.alu_op), 0);
        check_eq("rst_res_valid", 16'(bus.res_valid), 0);
        check_eq("rst_cmd_ready", 16'(bus.cmd_ready), 0);
        check_eq("rst_busy",      16'(bus.busy), 1);

        // 1: clear pulse length after release
        rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 8 && n == 0; i++) begin
            tick();
            if (bus.alu_clr_n) n = i;
        end
        check_eq("t1_clr_cycles", 16'(n), 2);
        check_eq("t1_cmd_ready",  16'(bus.cmd_ready), 1);
        check_eq("t1_busy",       16'(bus.busy), 0);

        // 2: single op, start timing and capture-before-release
        push_one(4'h3);
        check_eq("t2_pop_start", 16'(bus.alu_start), 0);
        tick();
        check_eq("t2_alu_op",     16'(bus.alu_op), 16'h3);
        check_eq("t2_setup_start", 16'(bus.alu_start), 0);
        tick();
        check_eq("t2_start_rise", 16'(bus.alu_start), 1);
        early = 1'b0;
        w = 0;
        while (bus.alu_start && w < 60) begin
            if (bus.res_valid) early = 1'b1;
            tick();
            w++;
        end
        check_eq("t2_start_fell", 16'(bus.alu_start), 0);
        check_eq("t2_no_early",   16'(early), 0);
        check_eq("t2_res_valid",  16'(bus.res_valid), 1);
        check_eq("t2_res_data",   16'(bus.res_data), 16'hA);
        check_eq("t2_res_flag",   16'(bus.res_flag), 1);
        check_eq("t2_res_err",    16'(bus.res_err), 0);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check_eq("t2_consumed", 16'(bus.res_valid), 0);
        w = 0;
        while (bus.busy && w < 40) begin
            tick();
            w++;
        end
        check_eq("t2_idle", 16'(bus.busy), 0);

        // 3: fill the FIFO behind a stalled op; 5th push refused; in-order completion
        core_hold = 1'b1;
        push_one(4'h7);
        repeat (4) tick();
        check_eq("t3_stalled_req", 16'(bus.alu_start), 1);
        ops   = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h5};
        exp_d = '{4'hE, 4'h8, 4'hB, 4'hD, 4'h1};
        exp_f = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            bus.cmd_op    = ops[k];
            bus.cmd_valid = 1'b1;
            check_eq($sformatf("t3_ready%0d", k), 16'(bus.cmd_ready), (k < 4) ? 16'd1 : 16'd0);
            tick();
        end
        bus.cmd_valid = 1'b0;
        core_hold = 1'b0;
        for (int k = 0; k < 5; k++) begin
            get_result($sformatf("t3_res%0d", k), exp_d[k], exp_f[k]);
        end
        repeat (20) tick();
        check_eq("t3_no_extra", 16'(bus.res_valid), 0);
        check_eq("t3_idle",     16'(bus.busy), 0);

        // 4: back-pressure holds second op in REQ
        push_one(4'hA);
        push_one(4'hC);
        repeat (30) tick();
        check_eq("t4_req_held",   16'(bus.alu_start), 1);
        check_eq("t4_op_held",    16'(bus.alu_op), 16'hC);
        check_eq("t4_first_vld",  16'(bus.res_valid), 1);
        check_eq("t4_first_data", 16'(bus.res_data), 16'h3);
        repeat (5) tick();
        check_eq("t4_start_stable", 16'(bus.alu_start), 1);
        check_eq("t4_op_stable",    16'(bus.alu_op), 16'hC);
        bus.res_ready = 1'b1;
        tick();
        check_eq("t4_valid_kept",  16'(bus.res_valid), 1);
        check_eq("t4_second_data", 16'(bus.res_data), 16'h5);
        check_eq("t4_start_rel",   16'(bus.alu_start), 0);
        tick();
        bus.res_ready = 1'b0;
        check_eq("t4_drained", 16'(bus.res_valid), 0);
        repeat (20) tick();

        // 5: reset asserted while in REQ with a pending result and a queued op
        push_one(4'hF);
        w = 0;
        while (!bus.res_valid && w < 60) begin
            tick();
            w++;
        end
        check_eq("t5_pending_res", 16'(bus.res_valid), 1);
        core_hold = 1'b1;
        push_one(4'h6);
        push_one(4'h9);
        w = 0;
        while (!bus.alu_start && w < 60) begin
            tick();
            w++;
        end
        check_eq("t5_in_req", 16'(bus.alu_start), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_start", 16'(bus.alu_start), 0);
        check_eq("t5_rst_clr_n", 16'(bus.alu_clr_n), 0);
        check_eq("t5_rst_valid", 16'(bus.res_valid), 0);
        core_hold = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check_eq("t5_fifo_empty", 16'(bus.busy), 0);
        check_eq("t5_res_valid",  16'(bus.res_valid), 0);
        check_eq("t5_no_start",   16'(bus.alu_start), 0);

`ifdef ASYSEQ_TIMEOUT_EN
        // 6: ack never rises -> error result, clear pulse, next op runs
        core_hold = 1'b1;
        push_one(4'h2);
        push_one(4'h1);
        w = 0;
        while (!bus.alu_start && w < 20) begin
            tick();
            w++;
        end
        n = 0;
        while (bus.alu_start && n < 200) begin
            n++;
            tick();
        end
        check_eq("t6_req_cycles", 16'(n), 64);
        check_eq("t6_clear",      16'(bus.alu_clr_n), 0);
        core_hold = 1'b0;
        w = 0;
        while (!bus.res_valid && w < 10) begin
            tick();
            w++;
        end
        check_eq("t6_err_valid", 16'(bus.res_valid), 1);
        check_eq("t6_err_flag",  16'(bus.res_err), 1);
        check_eq("t6_err_data",  16'(bus.res_data), 0);
        check_eq("t6_err_rflag", 16'(bus.res_flag), 0);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        get_result("t6_next", 4'h8, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
